// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift arbiter slice.
//   - shift operation encodings used on req*_op
//   - requester id constants carried on rsp_id
//   - response-record field widths
//   - response-stage state encoding (EMPTY / FULL)
package shift_arbiter_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned AMT_W      = 4;
    localparam int unsigned OP_W       = 2;
    localparam int unsigned RSP_DATA_W = DATA_W;
    localparam int unsigned RSP_ID_W   = 1;

    typedef enum logic [OP_W-1:0] {
        OP_ROL = 2'b00,
        OP_SHL = 2'b01,
        OP_ROR = 2'b10,
        OP_SHR = 2'b11
    } shift_op_e;

    localparam logic [RSP_ID_W-1:0] PORT0 = 1'b0;
    localparam logic [RSP_ID_W-1:0] PORT1 = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a priority pointer.
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   req0, req1     - request valids
//   free           - downstream slot can take a result this cycle
//   grant0, grant1 - one-hot (or zero) grant, combinational
// The pointer only matters when both requesters are valid; after a grant to
// port k it favours port 1-k. Grants are forced low while in reset.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic free,
    output logic grant0,
    output logic grant1
);

    // prio = 0: port 0 wins a tie; prio = 1: port 1 wins a tie
    logic prio;

    assign grant0 = rst_n & free & req0 & (~req1 | ~prio);
    assign grant1 = rst_n & free & req1 & (~req0 |  prio);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (grant0) begin
            prio <= 1'b1;
        end else if (grant1) begin
            prio <= 1'b0;
        end
    end

endmodule

// File: rtl/shifter.sv
// Combinational 16-bit barrel shifter.
// Ports:
//   data_in  - operand
//   amount   - shift/rotate amount 0..15 (0 passes the operand unchanged)
//   op       - OP_ROL / OP_SHL / OP_ROR / OP_SHR
//   data_out - result
module shifter
    import shift_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] data_in,
    input  logic [AMT_W-1:0]  amount,
    input  shift_op_e         op,
    output logic [DATA_W-1:0] data_out
);

    // Rotates are taken from a doubled operand so no wrap-around term is
    // needed: the bits pushed out of one copy come in from the other.
    logic [2*DATA_W-1:0] doubled;
    logic [2*DATA_W-1:0] rol_wide;
    logic [2*DATA_W-1:0] ror_wide;

    assign doubled  = {data_in, data_in};
    assign rol_wide = doubled << amount;
    assign ror_wide = doubled >> amount;

    always_comb begin
        data_out = data_in;
        case (op)
            OP_ROL:  data_out = rol_wide[2*DATA_W-1:DATA_W];
            OP_SHL:  data_out = data_in << amount;
            OP_ROR:  data_out = ror_wide[DATA_W-1:0];
            OP_SHR:  data_out = data_in >> amount;
            default: data_out = data_in;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one barrel shifter between two requesters with round-robin
// arbitration and a single registered response stage.
//
// Handshake: a transfer happens on a port in any cycle where its valid and
// ready are both 1 at the rising edge. Ready never depends on the
// requester's own valid being high beyond the grant rule, and a requester
// that sees ready=0 keeps valid and payload stable until it is accepted.
//
// Ports:
//   clk, rst_n                       - clock, synchronous active-low reset
//   req{0,1}_valid / _ready          - request handshake
//   req{0,1}_in / _cnt / _op / _tag  - operand, amount, operation, tag
//   rsp_valid / rsp_ready            - response handshake
//   rsp_data / rsp_id / rsp_tag      - result, issuing port, passthrough tag
//   conflicts                        - saturating count of contended grants
//   dbg_state                        - response-stage state (EMPTY/FULL)
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int unsigned TAG_W = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_W-1:0]     req0_in,
    input  logic [AMT_W-1:0]      req0_cnt,
    input  logic [OP_W-1:0]       req0_op,
    input  logic [TAG_W-1:0]      req0_tag,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_W-1:0]     req1_in,
    input  logic [AMT_W-1:0]      req1_cnt,
    input  logic [OP_W-1:0]       req1_op,
    input  logic [TAG_W-1:0]      req1_tag,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [RSP_DATA_W-1:0] rsp_data,
    output logic [RSP_ID_W-1:0]   rsp_id,
    output logic [TAG_W-1:0]      rsp_tag,

    output logic [CNT_W-1:0]      conflicts,
    output rsp_state_e            dbg_state
);

    rsp_state_e          state;
    rsp_state_e          state_next;

    logic                free;
    logic                grant0;
    logic                grant1;
    logic                any_grant;

    logic [DATA_W-1:0]   sh_in;
    logic [AMT_W-1:0]    sh_cnt;
    shift_op_e           sh_op;
    logic [DATA_W-1:0]   sh_out;
    logic [TAG_W-1:0]    sel_tag;

    // The slot can accept a new result if empty or being drained this cycle,
    // which is what allows one operation per cycle at full rate.
    assign free      = ~rsp_valid | rsp_ready;
    assign any_grant = grant0 | grant1;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (req0_valid),
        .req1   (req1_valid),
        .free   (free),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    // Operand mux: port 1 drives the shifter only when it holds the grant.
    always_comb begin
        sh_in   = req0_in;
        sh_cnt  = req0_cnt;
        sh_op   = shift_op_e'(req0_op);
        sel_tag = req0_tag;
        if (grant1) begin
            sh_in   = req1_in;
            sh_cnt  = req1_cnt;
            sh_op   = shift_op_e'(req1_op);
            sel_tag = req1_tag;
        end
    end

    shifter u_shifter (
        .data_in  (sh_in),
        .amount   (sh_cnt),
        .op       (sh_op),
        .data_out (sh_out)
    );

    // Response-stage FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Response-stage FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: if (any_grant) state_next = ST_FULL;
            ST_FULL:  if (!any_grant && rsp_ready) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
    end

    // Response-stage FSM: outputs
    always_comb begin
        rsp_valid = (state == ST_FULL);
        dbg_state = state;
    end

    // Response payload: loaded on every grant, otherwise held (including
    // while stalled and after a drain).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_id   <= PORT0;
            rsp_tag  <= '0;
        end else if (any_grant) begin
            rsp_data <= sh_out;
            rsp_id   <= grant1 ? PORT1 : PORT0;
            rsp_tag  <= sel_tag;
        end
    end

    // Contention counter: a cycle counts when both ports want the shifter
    // and the slot is free, i.e. exactly one of them is turned away.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflicts <= '0;
        end else if (req0_valid && req1_valid && free && (conflicts != '1)) begin
            conflicts <= conflicts + 1'b1;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter. A behavioural model (response slot,
// tie-break pointer, unbounded contention count, bitwise shift reference)
// is advanced on every falling edge from the inputs then present and the
// DUT outputs are compared against it; directed literal checks pin the
// model to hand-computed values. A second instance with CNT_W=4 shares the
// stimulus to exercise counter saturation.
module tb_shift_arbiter;
    import shift_arbiter_pkg::*;

    localparam int TAG_W = 3;

    logic              clk;
    logic              rst_n;
    logic              req0_valid, req1_valid;
    logic [15:0]       req0_in, req1_in;
    logic [3:0]        req0_cnt, req1_cnt;
    logic [1:0]        req0_op, req1_op;
    logic [TAG_W-1:0]  req0_tag, req1_tag;
    logic              rsp_ready;

    logic              req0_ready, req1_ready, rsp_valid;
    logic [15:0]       rsp_data;
    logic              rsp_id;
    logic [TAG_W-1:0]  rsp_tag;
    logic [15:0]       conflicts;
    rsp_state_e        dbg_state;

    logic              s_req0_ready, s_req1_ready, s_rsp_valid;
    logic [15:0]       s_rsp_data;
    logic              s_rsp_id;
    logic [TAG_W-1:0]  s_rsp_tag;
    logic [3:0]        s_conflicts;
    rsp_state_e        s_dbg_state;

    int checks = 0;
    int errors = 0;

    shift_arbiter #(.TAG_W(TAG_W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in(req0_in),
        .req0_cnt(req0_cnt), .req0_op(req0_op), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in(req1_in),
        .req1_cnt(req1_cnt), .req1_op(req1_op), .req1_tag(req1_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_tag(rsp_tag), .conflicts(conflicts),
        .dbg_state(dbg_state)
    );

    shift_arbiter #(.TAG_W(TAG_W), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_in(req0_in),
        .req0_cnt(req0_cnt), .req0_op(req0_op), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_in(req1_in),
        .req1_cnt(req1_cnt), .req1_op(req1_op), .req1_tag(req1_tag),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(s_rsp_data),
        .rsp_id(s_rsp_id), .rsp_tag(s_rsp_tag), .conflicts(s_conflicts),
        .dbg_state(s_dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] ref_shift(input logic [15:0] x, input int c, input logic [1:0] op);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            case (op)
                2'b00: r[(i + c) % 16] = x[i];
                2'b01: if (i + c < 16) r[i + c] = x[i];
                2'b10: r[(i - c + 16) % 16] = x[i];
                default: if (i - c >= 0) r[i - c] = x[i];
            endcase
        end
        return r;
    endfunction

    logic        m_valid = 1'b0;
    logic [15:0] m_data  = '0;
    logic        m_id    = 1'b0;
    logic [TAG_W-1:0] m_tag = '0;
    int          m_conf  = 0;
    int          m_turn  = 0;   // port that wins the next tie

    always @(negedge clk) begin : compare
        bit free, g0, g1;
        free = !m_valid || rsp_ready;
        g0 = rst_n && free && req0_valid && (!req1_valid || m_turn == 0);
        g1 = rst_n && free && req1_valid && (!req0_valid || m_turn == 1);

        check("req0_ready", req0_ready, g0);
        check("req1_ready", req1_ready, g1);
        check("rsp_valid",  rsp_valid,  m_valid);
        check("rsp_data",   rsp_data,   m_data);
        check("rsp_id",     rsp_id,     m_id);
        check("rsp_tag",    rsp_tag,    m_tag);
        check("conflicts",  conflicts,  (m_conf > 65535) ? 65535 : m_conf);
        check("dbg_state",  (dbg_state == ST_FULL), m_valid);
        check("sat_conflicts", s_conflicts, (m_conf > 15) ? 15 : m_conf);
        check("sat_rsp_data",  s_rsp_data,  m_data);

        if (!rst_n) begin
            m_valid = 1'b0; m_data = '0; m_id = 1'b0; m_tag = '0;
            m_conf = 0; m_turn = 0;
        end else begin
            if (req0_valid && req1_valid && free) m_conf++;
            if (g0) begin
                m_data = ref_shift(req0_in, int'(req0_cnt), req0_op);
                m_id = 1'b0; m_tag = req0_tag; m_valid = 1'b1; m_turn = 1;
            end else if (g1) begin
                m_data = ref_shift(req1_in, int'(req1_cnt), req1_op);
                m_id = 1'b1; m_tag = req1_tag; m_valid = 1'b1; m_turn = 0;
            end else if (m_valid && rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req0(input logic v, input logic [15:0] d, input logic [3:0] c,
                            input logic [1:0] op, input logic [TAG_W-1:0] t);
        req0_valid = v; req0_in = d; req0_cnt = c; req0_op = op; req0_tag = t;
    endtask

    task automatic set_req1(input logic v, input logic [15:0] d, input logic [3:0] c,
                            input logic [1:0] op, input logic [TAG_W-1:0] t);
        req1_valid = v; req1_in = d; req1_cnt = c; req1_op = op; req1_tag = t;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        set_req0(1'b0, '0, '0, '0, '0);
        set_req1(1'b0, '0, '0, '0, '0);
        repeat (2) next_cycle();
        rst_n = 1'b1;

        // reset state
        @(negedge clk);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_data", rsp_data, 0);
        check("reset conflicts", conflicts, 0);

        // single op: rotl 0x8001 by 1
        next_cycle();
        set_req0(1'b1, 16'h8001, 4'd1, 2'b00, 3'd5);
        @(negedge clk);
        check("single req0_ready", req0_ready, 1);
        next_cycle();
        req0_valid = 1'b0;
        @(negedge clk);
        check("single rsp_valid", rsp_valid, 1);
        check("single rsp_data", rsp_data, 16'h0003);
        check("single rsp_id", rsp_id, 0);
        check("single rsp_tag", rsp_tag, 5);
        check("single conflicts", conflicts, 0);

        // backpressure: shr 0x8000 by 15, then a second port-1 op waits
        next_cycle();
        set_req1(1'b1, 16'h8000, 4'd15, 2'b11, 3'd2);
        next_cycle();
        rsp_ready = 1'b0;
        set_req1(1'b1, 16'h00F0, 4'd4, 2'b11, 3'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall rsp_valid", rsp_valid, 1);
            check("stall rsp_data", rsp_data, 16'h0001);
            check("stall rsp_id", rsp_id, 1);
            check("stall req0_ready", req0_ready, 0);
            check("stall req1_ready", req1_ready, 0);
            next_cycle();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("release req1_ready", req1_ready, 1);
        next_cycle();
        req1_valid = 1'b0;
        @(negedge clk);
        check("release rsp_data", rsp_data, 16'h000F);
        check("release rsp_tag", rsp_tag, 3);

        // contention: grants alternate 0,1,0,1
        next_cycle();
        set_req0(1'b1, 16'h00FF, 4'd4, 2'b01, 3'd1);
        set_req1(1'b1, 16'h0001, 4'd1, 2'b10, 3'd6);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("contend req0_ready", req0_ready, (i % 2 == 0));
            check("contend req1_ready", req1_ready, (i % 2 == 1));
            next_cycle();
            if (i == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            @(negedge clk);
            check("contend rsp_id", rsp_id, i % 2);
            check("contend rsp_data", rsp_data, (i % 2 == 0) ? 16'h0FF0 : 16'h8000);
        end
        check("contend conflicts", conflicts, 4);

        // back-to-back: port 0 streams tags 0..7, shl 1 by tag
        next_cycle();
        set_req0(1'b1, 16'h0001, 4'd0, 2'b01, 3'd0);
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            if (i < 7) set_req0(1'b1, 16'h0001, 4'(i + 1), 2'b01, 3'(i + 1));
            else req0_valid = 1'b0;
            @(negedge clk);
            check("stream rsp_valid", rsp_valid, 1);
            check("stream rsp_tag", rsp_tag, i);
            check("stream rsp_data", rsp_data, 32'h1 << i);
        end

        // reset while a result is stalled
        next_cycle();
        set_req0(1'b1, 16'h00F0, 4'd2, 2'b00, 3'd7);
        next_cycle();
        req0_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("prereset rsp_valid", rsp_valid, 1);
        next_cycle();
        rst_n = 1'b0;
        set_req0(1'b1, 16'h1234, 4'd0, 2'b01, 3'd1);
        set_req1(1'b1, 16'h00FF, 4'd8, 2'b00, 3'd2);
        @(negedge clk);
        check("inreset req0_ready", req0_ready, 0);
        check("inreset req1_ready", req1_ready, 0);
        next_cycle();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("postreset rsp_valid", rsp_valid, 0);
        check("postreset conflicts", conflicts, 0);
        check("postreset req0_ready", req0_ready, 1);
        check("postreset req1_ready", req1_ready, 0);
        next_cycle();
        @(negedge clk);
        check("postreset rsp_id", rsp_id, 0);
        check("postreset rsp_data", rsp_data, 16'h1234);

        // saturation: 20 contention cycles in total since reset
        repeat (19) next_cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check("sat conflicts16", conflicts, 20);
        check("sat conflicts4", s_conflicts, 4'hF);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 16-bit barrel shifter (module `shifter`, combinational) between two requesters, e.g. execute-stage ALU (port 0) and memory byte-alignment unit (port 1).
- Valid/ready handshake on each request port; round-robin arbitration; single registered response stage.
- Response carries the requester id and a passthrough tag.
- Saturating conflict counter for performance monitoring.

Parameters:
TAG_W, 3, width of the opaque tag passed from request to response
CNT_W, 16, width of the saturating conflict counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle when valid&ready
req0_in  input  16  operand
req0_cnt  input  4  shift/rotate amount 0..15
req0_op  input  2  00 rotl, 01 shl, 10 rotr, 11 shr logical
req0_tag  input  TAG_W  opaque tag
req1_valid/req1_ready/req1_in/req1_cnt/req1_op/req1_tag  same as port 0
rsp_valid  output  1  response register holds a result
rsp_ready  input  1  consumer accepts the result when rsp_valid&rsp_ready
rsp_data  output  16  shifted result
rsp_id  output  1  requester that issued the result
rsp_tag  output  TAG_W  tag of the issuing request
conflicts  output  CNT_W  cycles in which both ports were valid and one was granted

Behaviour:
- Reset (rst_n=0 at edge): rsp_valid=0, rsp_data=0, rsp_id=0, rsp_tag=0, conflicts=0, priority pointer -> port 0.
- Reset mid-operation: any held result is discarded.
- req*_ready is combinational and 0 while rst_n=0.
- Slot free: free = !rsp_valid | rsp_ready.
- Grant rule:
  - Only one valid: that port is granted if free.
  - Both valid: the port named by the priority pointer is granted.
  - Nothing is granted when !free.
- req0_ready/req1_ready = grant to that port. The loser sees ready=0 and must hold its inputs stable.
- Priority pointer: after a grant to port k it points to port 1-k. Unchanged when there is no grant.
- Datapath: the granted request's in/cnt/op drives the shared shifter through a 2:1 operand mux.
- On grant, at the edge:
  - rsp_data <= shifter output, rsp_id <= k, rsp_tag <= tag, rsp_valid <= 1.
  - Latency is exactly one cycle from acceptance to rsp_valid.
- No grant but rsp_valid&rsp_ready: rsp_valid <= 0, other response fields hold.
- Simultaneous drain and grant in the same cycle: the new result replaces the old one, rsp_valid stays 1. This gives full throughput of one op/cycle.
- Backpressure: while rsp_valid&!rsp_ready, rsp_data/id/tag are held stable and both readies are 0.
- conflicts increments when both valid and free. It saturates at all-ones and never wraps.
- Shift semantics per op, cnt=0 returns operand unchanged:
  - rotl/rotr: circular.
  - shl: zero-fill from the LSB side.
  - shr: zero-fill from the MSB side.
- States: EMPTY (rsp_valid=0) and FULL (rsp_valid=1). Transitions:
  - EMPTY->FULL on any grant.
  - FULL->EMPTY on drain with no grant.
  - FULL->FULL on stall, or on drain with grant.

Decomposition:
- Shared package: op encodings (OP_ROL=2'b00, OP_SHL=2'b01, OP_ROR=2'b10, OP_SHR=2'b11), port id constants, and the response-record field widths.
- One sub-module instance: the existing `shifter`.
- The arbiter (grant logic plus priority pointer) may be a small sub-module, rr_arb2.

Test Plan:
- Single op: port 0, in=0x8001, cnt=1, op=00; rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=0x0003, rsp_id=0. conflicts stays 0.
- Contention and fairness:
  - Setup: both ports valid for 4 cycles.
    - Port 0: in=0x00FF, cnt=4, op=01.
    - Port 1: in=0x0001, cnt=1, op=10.
  - Grants alternate 0,1,0,1.
  - Responses alternate 0x0FF0 / 0x8000.
  - conflicts=4.
- Backpressure: port 1, in=0x8000, cnt=15, op=11; rsp_ready=0 for 3 cycles.
  - rsp_data=0x0001 held.
  - Both readies stay 0.
  - On release: one drain, then new grants resume.
- Back-to-back at full rate: port 0 streams tags 0..7 with rsp_ready=1. Expect 8 responses in 8 consecutive cycles, tags in order.
- Reset mid-stall: assert rst_n=0 while rsp_valid=1 -> next edge rsp_valid=0, conflicts=0, and the first subsequent contention grants port 0.
- Saturation: force CNT_W=4 with 20 contention cycles -> conflicts stops at 0xF.
